// File: rtl/game_pkg.sv
// ============================================================================
// Module : game_pkg
// Brief  : Shared sprite ids, directions, reset positions and widths.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int POS_X_W = 11;
    localparam int POS_Y_W = 10;

    // One-hot move directions
    localparam logic [3:0] RIGHT = 4'b0001;
    localparam logic [3:0] UP    = 4'b0010;
    localparam logic [3:0] DOWN  = 4'b0100;
    localparam logic [3:0] LEFT  = 4'b1000;

    typedef enum logic [2:0] {
        PACMAN = 3'd0,
        BLINKY = 3'd1,
        PINKY  = 3'd2,
        INKY   = 3'd3,
        CLYDE  = 3'd4
    } sprite_id_t;

    localparam logic [POS_X_W-1:0] PACMAN_RST_X = 11'd615;
    localparam logic [POS_Y_W-1:0] PACMAN_RST_Y = 10'd482;
    localparam logic [POS_X_W-1:0] BLINKY_RST_X = 11'd663;
    localparam logic [POS_Y_W-1:0] BLINKY_RST_Y = 10'd434;
    localparam logic [POS_X_W-1:0] PINKY_RST_X  = 11'd615;
    localparam logic [POS_Y_W-1:0] PINKY_RST_Y  = 10'd258;
    localparam logic [POS_X_W-1:0] INKY_RST_X   = 11'd503;
    localparam logic [POS_Y_W-1:0] INKY_RST_Y   = 10'd66;
    localparam logic [POS_X_W-1:0] CLYDE_RST_X  = 11'd615;
    localparam logic [POS_Y_W-1:0] CLYDE_RST_Y  = 10'd370;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'b0001)) == 4'b0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ghost_collision_cmp.sv
// ============================================================================
// Module : ghost_collision_cmp
// Brief  : Combinational |dx|<HIT_DIST && |dy|<HIT_DIST sprite overlap test.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ghost_collision_cmp
    import game_pkg::*;
#(
    parameter int HIT_DIST = 16
) (
    input  logic [POS_X_W-1:0] ax,
    input  logic [POS_Y_W-1:0] ay,
    input  logic [POS_X_W-1:0] bx,
    input  logic [POS_Y_W-1:0] by,
    output logic               hit
);

    logic signed [POS_X_W:0] dx;
    logic signed [POS_Y_W:0] dy;
    logic        [POS_X_W:0] adx;
    logic        [POS_Y_W:0] ady;

    // One extra bit keeps the difference exact, so magnitudes never wrap
    always_comb begin
        dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
        adx = dx[POS_X_W] ? (~dx + 1'b1) : dx;
        ady = dy[POS_Y_W] ? (~dy + 1'b1) : dy;
        hit = (adx < (POS_X_W + 1)'(HIT_DIST)) && (ady < (POS_Y_W + 1)'(HIT_DIST));
    end

endmodule

`default_nettype wire

// File: rtl/ghost_update_scheduler.sv
// ============================================================================
// Module : ghost_update_scheduler
// Brief  : Round-robin time-sharing of one ghost update unit across 4 slots.
//          Optional pacman collision check under `COLLISION_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ghost_update_scheduler
    import game_pkg::*;
#(
    parameter int NUM_GHOSTS = 4,
    parameter int TIMEOUT    = 16,
    parameter int HIT_DIST   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [3:0]  ghost_en,
    input  logic [10:0] pacman_pos_x,
    input  logic [9:0]  pacman_pos_y,
    output logic        unit_start,
    output logic [1:0]  unit_ghost_id,
    output logic [10:0] unit_pos_x,
    output logic [9:0]  unit_pos_y,
    output logic [3:0]  unit_prev_dir,
    input  logic        unit_done,
    input  logic [10:0] unit_new_x,
    input  logic [9:0]  unit_new_y,
    input  logic [3:0]  unit_dir,
    output logic [43:0] ghost_pos_x,
    output logic [39:0] ghost_pos_y,
    output logic [15:0] ghost_dir,
    output logic        busy,
    output logic        round_done,
    output logic        overrun,
    output logic        timeout_err,
    output logic        pacman_is_dead
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 2);

    localparam logic [3:0][POS_X_W-1:0] RST_X = {CLYDE_RST_X, INKY_RST_X, PINKY_RST_X, BLINKY_RST_X};
    localparam logic [3:0][POS_Y_W-1:0] RST_Y = {CLYDE_RST_Y, INKY_RST_Y, PINKY_RST_Y, BLINKY_RST_Y};

    sched_state_t                state_q, state_d;
    logic [1:0]                  idx_q, idx_d;
    logic [TMR_W-1:0]            timer_q, timer_d;
    logic [3:0][POS_X_W-1:0]     pos_x_q, pos_x_d;
    logic [3:0][POS_Y_W-1:0]     pos_y_q, pos_y_d;
    logic [3:0][3:0]             dir_q, dir_d;
    logic                        unit_start_q, unit_start_d;
    logic [1:0]                  unit_ghost_id_q, unit_ghost_id_d;
    logic [POS_X_W-1:0]          unit_pos_x_q, unit_pos_x_d;
    logic [POS_Y_W-1:0]          unit_pos_y_q, unit_pos_y_d;
    logic [3:0]                  unit_prev_dir_q, unit_prev_dir_d;
    logic                        busy_q, busy_d;
    logic                        round_done_q, round_done_d;
    logic                        overrun_q, overrun_d;
    logic                        timeout_err_q, timeout_err_d;
    logic                        pacman_is_dead_q, pacman_is_dead_d;
    logic                        w_commit;
    logic                        w_hit;

    function automatic logic slot_enabled(input logic [1:0] id, input logic [3:0] en);
        return en[id] && (int'(id) < NUM_GHOSTS);
    endfunction

`ifdef COLLISION_CHECK_EN
    ghost_collision_cmp #(
        .HIT_DIST (HIT_DIST)
    ) u_collision_cmp (
        .ax  (unit_new_x),
        .ay  (unit_new_y),
        .bx  (pacman_pos_x),
        .by  (pacman_pos_y),
        .hit (w_hit)
    );
`else
    logic unused_cfg;
    assign w_hit      = 1'b0;
    assign unused_cfg = ^{pacman_pos_x, pacman_pos_y, w_commit, w_hit, 1'(HIT_DIST)};
`endif

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        timer_d          = timer_q;
        pos_x_d          = pos_x_q;
        pos_y_d          = pos_y_q;
        dir_d            = dir_q;
        timeout_err_d    = timeout_err_q;
        w_commit         = 1'b0;
        overrun_d        = overrun_q | (frame_tick && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (frame_tick && !pacman_is_dead_q) begin
                    state_d = ST_ISSUE;
                    idx_d   = 2'd0;
                end
            end
            ST_ISSUE: begin
                if (slot_enabled(idx_q, ghost_en)) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end else if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_WAIT: begin
                if (unit_done || (timer_q == TMR_LAST)) begin
                    if (unit_done) begin
                        w_commit       = 1'b1;
                        pos_x_d[idx_q] = unit_new_x;
                        pos_y_d[idx_q] = unit_new_y;
                        if (is_onehot4(unit_dir)) begin
                            dir_d[idx_q] = unit_dir;
                        end
                    end else begin
                        timeout_err_d = 1'b1;
                    end
                    if (idx_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase

`ifdef COLLISION_CHECK_EN
        pacman_is_dead_d = pacman_is_dead_q | (w_commit & w_hit);
`else
        pacman_is_dead_d = 1'b0;
`endif

        // Outputs look one state ahead so that they are registered yet
        // line up with the state they describe.
        unit_start_d    = (state_d == ST_ISSUE) && slot_enabled(idx_d, ghost_en);
        unit_ghost_id_d = idx_d;
        unit_pos_x_d    = pos_x_d[idx_d];
        unit_pos_y_d    = pos_y_d[idx_d];
        unit_prev_dir_d = dir_d[idx_d];
        busy_d          = (state_d != ST_IDLE);
        round_done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            idx_q            <= 2'd0;
            timer_q          <= '0;
            pos_x_q          <= RST_X;
            pos_y_q          <= RST_Y;
            dir_q            <= {4{LEFT}};
            unit_start_q     <= 1'b0;
            unit_ghost_id_q  <= 2'd0;
            unit_pos_x_q     <= BLINKY_RST_X;
            unit_pos_y_q     <= BLINKY_RST_Y;
            unit_prev_dir_q  <= LEFT;
            busy_q           <= 1'b0;
            round_done_q     <= 1'b0;
            overrun_q        <= 1'b0;
            timeout_err_q    <= 1'b0;
            pacman_is_dead_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            timer_q          <= timer_d;
            pos_x_q          <= pos_x_d;
            pos_y_q          <= pos_y_d;
            dir_q            <= dir_d;
            unit_start_q     <= unit_start_d;
            unit_ghost_id_q  <= unit_ghost_id_d;
            unit_pos_x_q     <= unit_pos_x_d;
            unit_pos_y_q     <= unit_pos_y_d;
            unit_prev_dir_q  <= unit_prev_dir_d;
            busy_q           <= busy_d;
            round_done_q     <= round_done_d;
            overrun_q        <= overrun_d;
            timeout_err_q    <= timeout_err_d;
            pacman_is_dead_q <= pacman_is_dead_d;
        end
    end

    assign unit_start     = unit_start_q;
    assign unit_ghost_id  = unit_ghost_id_q;
    assign unit_pos_x     = unit_pos_x_q;
    assign unit_pos_y     = unit_pos_y_q;
    assign unit_prev_dir  = unit_prev_dir_q;
    assign ghost_pos_x    = pos_x_q;
    assign ghost_pos_y    = pos_y_q;
    assign ghost_dir      = dir_q;
    assign busy           = busy_q;
    assign round_done     = round_done_q;
    assign overrun        = overrun_q;
    assign timeout_err    = timeout_err_q;
    assign pacman_is_dead = pacman_is_dead_q;

endmodule

`default_nettype wire
